// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A round-robin
//   arbiter picks one request per cycle, steers its decode fields and
//   operands to the ALU, and captures the ALU result into a one-entry
//   response register tagged with the owning requester.
//
//   Optional feature macro: ALU_ARB_FIXED_PRIO_EN
//     defined   -> req0 always wins a contest; no last-grant pointer exists
//     undefined -> round-robin between req0 and req1 (default build)
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous active-high reset
//   reqN_valid/ready       request handshake, N = 0,1
//   reqN_opcode/funct/add_rshift_type, reqN_a/b   request fields
//   dec_opcode/funct/add_rshift_type              fields to the shared decoder
//   alu_a, alu_b           operands to the shared ALU
//   alu_result             combinational ALU result for alu_a/alu_b
//   rspN_valid/ready       response handshake, N = 0,1
//   rsp_data               registered result, common to both responses
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [6:0]        req0_opcode,
   input  logic [2:0]        req0_funct,
   input  logic              req0_add_rshift_type,
   input  logic [DWIDTH-1:0] req0_a,
   input  logic [DWIDTH-1:0] req0_b,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [6:0]        req1_opcode,
   input  logic [2:0]        req1_funct,
   input  logic              req1_add_rshift_type,
   input  logic [DWIDTH-1:0] req1_a,
   input  logic [DWIDTH-1:0] req1_b,

   output logic [6:0]        dec_opcode,
   output logic [2:0]        dec_funct,
   output logic              dec_add_rshift_type,
   output logic [DWIDTH-1:0] alu_a,
   output logic [DWIDTH-1:0] alu_b,
   input  logic [DWIDTH-1:0] alu_result,

   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DWIDTH-1:0] rsp_data
);

   logic              rsp_valid_q;
   logic              rsp_owner_q;
   logic [DWIDTH-1:0] rsp_data_q;

   logic              slot_free;
   logic              any_valid;
   logic              winner;
   logic              accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Id of the requester granted most recently; resets to 1 so req0 wins
   // the first contest.
   logic              last_grant_q;
`endif

   // The slot can be refilled in the same cycle its owner drains it.
   always_comb begin
      slot_free = !rsp_valid_q || (rsp_owner_q ? rsp1_ready : rsp0_ready);
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         winner = 1'b0;
`else
         winner = ~last_grant_q;
`endif
      end else begin
         winner = req1_valid;
      end
      // Ready depends only on valids and slot state, never on request data.
      accept     = any_valid & slot_free & ~reset;
      req0_ready = accept & ~winner;
      req1_ready = accept &  winner;
   end

   always_comb begin
      dec_opcode          = '0;
      dec_funct           = '0;
      dec_add_rshift_type = 1'b0;
      alu_a               = '0;
      alu_b               = '0;
      if (any_valid) begin
         if (winner) begin
            dec_opcode          = req1_opcode;
            dec_funct           = req1_funct;
            dec_add_rshift_type = req1_add_rshift_type;
            alu_a               = req1_a;
            alu_b               = req1_b;
         end else begin
            dec_opcode          = req0_opcode;
            dec_funct           = req0_funct;
            dec_add_rshift_type = req0_add_rshift_type;
            alu_a               = req0_a;
            alu_b               = req0_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_data_q  <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_owner_q <= winner;
         rsp_data_q  <= alu_result;
      end else if (slot_free) begin
         // Drained (or already empty): data is kept, only valid drops.
         rsp_valid_q <= 1'b0;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= winner;
      end
   end
`endif

   assign rsp0_valid = rsp_valid_q & ~rsp_owner_q;
   assign rsp1_valid = rsp_valid_q &  rsp_owner_q;
   assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int DWIDTH = 32;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [6:0]        req0_opcode, req1_opcode;
   logic [2:0]        req0_funct, req1_funct;
   logic              req0_add_rshift_type, req1_add_rshift_type;
   logic [DWIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [6:0]        dec_opcode;
   logic [2:0]        dec_funct;
   logic              dec_add_rshift_type;
   logic [DWIDTH-1:0] alu_a, alu_b, alu_result;
   logic              rsp0_valid, rsp1_valid;
   logic              rsp0_ready, rsp1_ready;
   logic [DWIDTH-1:0] rsp_data;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DWIDTH(DWIDTH)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_opcode(req0_opcode), .req0_funct(req0_funct),
      .req0_add_rshift_type(req0_add_rshift_type), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_opcode(req1_opcode), .req1_funct(req1_funct),
      .req1_add_rshift_type(req1_add_rshift_type), .req1_a(req1_a), .req1_b(req1_b),
      .dec_opcode(dec_opcode), .dec_funct(dec_funct),
      .dec_add_rshift_type(dec_add_rshift_type),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data)
   );

   // RV32 integer ALU semantics: used both as the ALU the DUT drives and as
   // the reference for what a requester's operation should produce.
   function automatic logic [DWIDTH-1:0] alu_fn(input logic [6:0] op, input logic [2:0] f,
                                                input logic t, input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
      case (f)
         3'd0:    alu_fn = (t && op == OP_R) ? a - b : a + b;
         3'd1:    alu_fn = a << b[4:0];
         3'd2:    alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    alu_fn = (a < b) ? 32'd1 : 32'd0;
         3'd4:    alu_fn = a ^ b;
         3'd5:    alu_fn = t ? DWIDTH'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    alu_fn = a | b;
         default: alu_fn = a & b;
      endcase
   endfunction

   assign alu_result = alu_fn(dec_opcode, dec_funct, dec_add_rshift_type, alu_a, alu_b);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_req0(input logic v, input logic [6:0] op, input logic [2:0] f,
                           input logic t, input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
      req0_valid = v; req0_opcode = op; req0_funct = f;
      req0_add_rshift_type = t; req0_a = a; req0_b = b;
   endtask

   task automatic set_req1(input logic v, input logic [6:0] op, input logic [2:0] f,
                           input logic t, input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
      req1_valid = v; req1_opcode = op; req1_funct = f;
      req1_add_rshift_type = t; req1_a = a; req1_b = b;
   endtask

   task automatic idle_reqs();
      set_req0(1'b0, 7'd0, 3'd0, 1'b0, '0, '0);
      set_req1(1'b0, 7'd0, 3'd0, 1'b0, '0, '0);
   endtask

   task automatic pulse_reset();
      idle_reqs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req0(1'b1, OP_R, 3'd0, 1'b0, 32'd1, 32'd2);
      set_req1(1'b1, OP_R, 3'd0, 1'b0, 32'd3, 32'd4);
      repeat (2) begin
         settle();
         vectors++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
         end
         tick();
         vectors++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rsp: got valid=%b data=%0h expected valid=00 data=0",
                     {rsp0_valid, rsp1_valid}, rsp_data);
         end
      end
      reset = 1'b0;
      idle_reqs();
      settle();
      vectors++;
      if (dec_opcode !== 7'd0 || dec_funct !== 3'd0 || dec_add_rshift_type !== 1'b0 ||
          alu_a !== '0 || alu_b !== '0 || {req0_ready, req1_ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_mux: got op=%0h f=%0h t=%b a=%0h b=%0h rdy=%b expected all zero",
                  dec_opcode, dec_funct, dec_add_rshift_type, alu_a, alu_b, {req0_ready, req1_ready});
      end
   endtask

   task automatic test_single_add();
      pulse_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req0(1'b1, OP_R, 3'd0, 1'b0, 32'd5, 32'd7);
      settle();
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b10 || alu_a !== 32'd5 || alu_b !== 32'd7 ||
          dec_opcode !== OP_R) begin
         miscompares++;
         $display("FAIL add_accept: got rdy=%b a=%0d b=%0d op=%0h expected rdy=10 a=5 b=7 op=33",
                  {req0_ready, req1_ready}, alu_a, alu_b, dec_opcode);
      end
      tick();
      idle_reqs();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_data !== 32'd12) begin
         miscompares++;
         $display("FAIL add_rsp: got valid=%b data=%0d expected valid=10 data=12",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
      tick();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_data !== 32'd12) begin
         miscompares++;
         $display("FAIL add_drain: got valid=%b data=%0d expected valid=00 data=12",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
   endtask

   task automatic test_round_robin();
      int exp_g[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif
      pulse_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req0(1'b1, OP_R, 3'd0, 1'b0, 32'd1, 32'd1);
      set_req1(1'b1, OP_R, 3'd0, 1'b0, 32'd2, 32'd2);
      for (int i = 0; i < 4; i++) begin
         settle();
         vectors++;
         if (req0_ready !== (exp_g[i] == 0) || req1_ready !== (exp_g[i] == 1)) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got rdy=%b expected winner req%0d", i,
                     {req0_ready, req1_ready}, exp_g[i]);
         end
         tick();
         vectors++;
         if (rsp0_valid !== (exp_g[i] == 0) || rsp1_valid !== (exp_g[i] == 1) ||
             rsp_data !== ((exp_g[i] == 1) ? 32'd4 : 32'd2)) begin
            miscompares++;
            $display("FAIL rr_rsp%0d: got valid=%b data=%0d expected owner req%0d", i,
                     {rsp0_valid, rsp1_valid}, rsp_data, exp_g[i]);
         end
      end
      idle_reqs();
      tick();
   endtask

   task automatic test_backpressure();
      logic exp_w;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = 1'b1;
`endif
      pulse_reset();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req0(1'b1, OP_R, 3'd0, 1'b0, 32'd1, 32'd2);
      tick();
      set_req0(1'b1, OP_R, 3'd0, 1'b0, 32'd100, 32'd1);
      set_req1(1'b1, OP_R, 3'd0, 1'b0, 32'd200, 32'd2);
      // rsp1_ready toggled while rsp1 is empty must not free the slot.
      for (int i = 0; i < 3; i++) begin
         rsp1_ready = (i != 1);
         settle();
         vectors++;
         if ({req0_ready, req1_ready} !== 2'b00 || {rsp0_valid, rsp1_valid} !== 2'b10 ||
             rsp_data !== 32'd3) begin
            miscompares++;
            $display("FAIL stall%0d: got rdy=%b valid=%b data=%0d expected rdy=00 valid=10 data=3",
                     i, {req0_ready, req1_ready}, {rsp0_valid, rsp1_valid}, rsp_data);
         end
         tick();
      end
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      settle();
      vectors++;
      if (req0_ready !== ~exp_w || req1_ready !== exp_w) begin
         miscompares++;
         $display("FAIL stall_release: got rdy=%b expected winner req%0d",
                  {req0_ready, req1_ready}, exp_w);
      end
      tick();
      idle_reqs();
      vectors++;
      if (rsp0_valid !== ~exp_w || rsp1_valid !== exp_w ||
          rsp_data !== (exp_w ? 32'd202 : 32'd101)) begin
         miscompares++;
         $display("FAIL stall_refill: got valid=%b data=%0d expected owner req%0d",
                  {rsp0_valid, rsp1_valid}, rsp_data, exp_w);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req1(1'b1, OP_R, 3'd0, 1'b1, 32'd10, 32'd3);
      settle();
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b01 || dec_add_rshift_type !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_sub_accept: got rdy=%b t=%b expected rdy=01 t=1",
                  {req0_ready, req1_ready}, dec_add_rshift_type);
      end
      tick();
      set_req1(1'b1, OP_R, 3'd4, 1'b0, 32'hF0, 32'h0F);
      settle();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_data !== 32'd7 || req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_sub_rsp: got valid=%b data=%0h rdy1=%b expected valid=01 data=7 rdy1=1",
                  {rsp0_valid, rsp1_valid}, rsp_data, req1_ready);
      end
      tick();
      idle_reqs();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_data !== 32'hFF) begin
         miscompares++;
         $display("FAIL b2b_xor_rsp: got valid=%b data=%0h expected valid=01 data=ff",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req1(1'b1, OP_R, 3'd0, 1'b0, 32'd4, 32'd4);
      tick();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_data !== 32'd8) begin
         miscompares++;
         $display("FAIL midrst_setup: got valid=%b data=%0d expected valid=01 data=8",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
      reset = 1'b1;
      rsp1_ready = 1'b1;
      settle();
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         miscompares++; $display("FAIL midrst_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      tick();
      reset = 1'b0;
      rsp1_ready = 1'b0;
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_data !== 32'd0) begin
         miscompares++;
         $display("FAIL midrst_clear: got valid=%b data=%0d expected valid=00 data=0",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
      set_req0(1'b1, OP_R, 3'd6, 1'b0, 32'h30, 32'h03);
      settle();
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++; $display("FAIL midrst_first: got %b expected 10", {req0_ready, req1_ready});
      end
      tick();
      idle_reqs();
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_data !== 32'h33) begin
         miscompares++;
         $display("FAIL midrst_rsp: got valid=%b data=%0h expected valid=10 data=33",
                  {rsp0_valid, rsp1_valid}, rsp_data);
      end
      rsp0_ready = 1'b1;
      tick();
   endtask

   // Reference: a one-entry mailbox. A requester is served when the mailbox
   // is empty or being emptied this cycle; a tie goes to whoever was not
   // served most recently (always req0 with fixed priority).
   task automatic test_random();
      logic              box_full;
      int                box_owner;
      logic [DWIDTH-1:0] box_data;
      int                last_served;
      int                served;
      logic              can_take;
      logic [DWIDTH-1:0] want_result;
      pulse_reset();
      box_full = 1'b0; box_owner = 0; box_data = '0; last_served = 1;
      for (int n = 0; n < 400; n++) begin
         set_req0($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? OP_R : OP_I,
                  3'($urandom), 1'($urandom), $urandom, $urandom);
         set_req1($urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? OP_R : OP_I,
                  3'($urandom), 1'($urandom), $urandom, $urandom);
         rsp0_ready = $urandom_range(0, 2) != 0;
         rsp1_ready = $urandom_range(0, 2) != 0;
         settle();

         can_take = !box_full || (box_owner == 0 ? rsp0_ready : rsp1_ready);
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            served = 0;
`else
            served = 1 - last_served;
`endif
         end else if (req0_valid)
            served = 0;
         else if (req1_valid)
            served = 1;
         else
            served = -1;

         vectors++;
         if (req0_ready !== (can_take && served == 0) || req1_ready !== (can_take && served == 1)) begin
            miscompares++;
            $display("FAIL rand_ready@%0d: got rdy=%b expected served=%0d can_take=%b", n,
                     {req0_ready, req1_ready}, served, can_take);
         end
         vectors++;
         if (served == 0 && (dec_opcode !== req0_opcode || dec_funct !== req0_funct ||
             dec_add_rshift_type !== req0_add_rshift_type || alu_a !== req0_a || alu_b !== req0_b) ||
             served == 1 && (dec_opcode !== req1_opcode || dec_funct !== req1_funct ||
             dec_add_rshift_type !== req1_add_rshift_type || alu_a !== req1_a || alu_b !== req1_b) ||
             served == -1 && (dec_opcode !== 7'd0 || dec_funct !== 3'd0 ||
             dec_add_rshift_type !== 1'b0 || alu_a !== '0 || alu_b !== '0)) begin
            miscompares++;
            $display("FAIL rand_mux@%0d: got op=%0h f=%0h a=%0h b=%0h expected fields of req%0d",
                     n, dec_opcode, dec_funct, alu_a, alu_b, served);
         end

         if (can_take && served >= 0) begin
            want_result = (served == 0)
               ? alu_fn(req0_opcode, req0_funct, req0_add_rshift_type, req0_a, req0_b)
               : alu_fn(req1_opcode, req1_funct, req1_add_rshift_type, req1_a, req1_b);
            box_full = 1'b1; box_owner = served; box_data = want_result; last_served = served;
         end else if (can_take) begin
            box_full = 1'b0;
         end
         tick();
         vectors++;
         if (rsp0_valid !== (box_full && box_owner == 0) || rsp1_valid !== (box_full && box_owner == 1) ||
             rsp_data !== box_data) begin
            miscompares++;
            $display("FAIL rand_rsp@%0d: got valid=%b data=%0h expected full=%b owner=%0d data=%0h",
                     n, {rsp0_valid, rsp1_valid}, rsp_data, box_full, box_owner, box_data);
         end
      end
      idle_reqs();
   endtask

   initial begin
      idle_reqs();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      reset = 1'b1;
      test_reset();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
